dec_scan_sequencer: RTL and testbench
=====================================

Name: dec_scan_sequencer

Overview:
- Registered address generator that drives the 4-bit select code of the 4x16 one-hot decoder.
- Steps through a programmable address window [first..last] and holds each address for a programmable dwell time.
- Runs single-shot or continuous, with start/stop/hold control and a completion pulse.
- Sits directly upstream of the decoder: sel feeds the decoder's 4-bit input, and sel_valid gates the decoder enable.

Parameters:
- DWELL_W, 8, width of the dwell-count input and internal dwell counter.
- PASS_W, 8, width of the continuous-mode pass counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  begin a scan; sampled only in IDLE.
- stop  input  1  abort the scan; sampled in RUN.
- hold  input  1  freeze the scan (dwell counter and sel) while high in RUN.
- mode_cont  input  1  latched at start: 0 = single pass, 1 = repeat until stop.
- first  input  4  start address, latched at start.
- last  input  4  end address, latched at start.
- dwell  input  DWELL_W  cycles-per-address minus one, latched at start.
- sel  output  4  current address to the decoder.
- sel_valid  output  1  sel is an active address (decoder enable).
- busy  output  1  scan in progress (state RUN).
- done  output  1  one-cycle pulse on single-pass completion.
- pass_cnt  output  PASS_W  completed passes in the current scan.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on rst.
- Reset values: sel=0, sel_valid=0, busy=0, done=0, pass_cnt=0, dwell counter=0, state=IDLE. rst overrides every other input on the same edge, including mid-RUN.
- States: IDLE, RUN. All outputs are registered; there is no combinational input-to-output path.
- IDLE, start=1 and stop=0 at edge N:
  - latch first, last, dwell, mode_cont;
  - after edge N: sel=first, sel_valid=1, busy=1, pass_cnt=0, cnt=dwell, state=RUN.
- IDLE, start=1 and stop=1 at the same edge: start is ignored and the block stays in IDLE.
- RUN, per edge, in priority order:
  - stop=1: go to IDLE, sel_valid=0, busy=0, done stays 0, sel holds its value.
  - hold=1: nothing changes.
  - cnt!=0: cnt decrements.
  - cnt==0 and sel!=last: sel=sel+1 modulo 16 (15 wraps to 0, so first>last scans through the wrap), cnt=dwell.
  - cnt==0, sel==last, mode_cont=1: sel=first, cnt=dwell, pass_cnt increments modulo 2^PASS_W.
  - cnt==0, sel==last, mode_cont=0: go to IDLE, sel_valid=0, busy=0, done=1 for exactly one cycle, pass_cnt=1, sel holds last.
- Dwell: each address is presented for dwell+1 non-held cycles. dwell=0 advances the address every cycle.
- first==last: a single address is presented for dwell+1 cycles per pass.
- Window length: (last-first) mod 16 + 1 addresses per pass, range 1..16.
- start during RUN: ignored. The latched configuration is not disturbed by input changes during RUN.
- done is cleared on the next edge. A start on the cycle done is high is accepted, since the state is already IDLE.
- pass_cnt holds its value in IDLE until the next accepted start.

Test Plan:
- Reset mid-RUN: start with first=2, last=5, dwell=3, then assert rst at cycle 6 -> next cycle all outputs equal their reset values and state=IDLE.
- Single pass: first=2, last=5, dwell=1, mode_cont=0, pulse start -> sel sequence 2,2,3,3,4,4,5,5 with sel_valid=1 throughout, then sel_valid=0, busy=0, done=1 for one cycle, pass_cnt=1, sel=5.
- Wrap and dwell=0: first=14, last=1, dwell=0, mode_cont=0 -> sel 14,15,0,1 on consecutive cycles, then done pulse. Same setup with first=last=7, dwell=4 -> sel=7 for exactly 5 cycles, then done.
- Continuous mode: first=0, last=15, dwell=0, mode_cont=1 -> sel 0..15 repeating and pass_cnt incrementing on each 15->0 transition. Assert stop after 40 cycles -> sel_valid=0 and busy=0 next cycle, done never asserts, pass_cnt=2 holds.
- Hold: first=3, last=4, dwell=2, assert hold for 5 cycles during the second cycle of address 3 -> address 3 is visible for 3+5=8 cycles and sel is frozen during the hold.
- Control collisions: start=1 and stop=1 together in IDLE -> remains IDLE. start re-pulsed during RUN with different first/last -> scan is unchanged. start on the done cycle -> new scan begins the next cycle with sel=first.

Source files
------------

// File: rtl/dec_scan_sequencer.sv
// Address sequencer for the 4x16 one-hot decoder: walks a latched window
// [first..last] with a per-address dwell, single-shot or continuous.
module dec_scan_sequencer #(
    parameter int DWELL_W = 8,
    parameter int PASS_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               hold,
    input  logic               mode_cont,
    input  logic [3:0]         first,
    input  logic [3:0]         last,
    input  logic [DWELL_W-1:0] dwell,
    output logic [3:0]         sel,
    output logic               sel_valid,
    output logic               busy,
    output logic               done,
    output logic [PASS_W-1:0]  pass_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state;
    logic [DWELL_W-1:0] cnt;
    logic [3:0]         first_q;
    logic [3:0]         last_q;
    logic [DWELL_W-1:0] dwell_q;
    logic               mode_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            first_q   <= '0;
            last_q    <= '0;
            dwell_q   <= '0;
            mode_q    <= 1'b0;
            sel       <= '0;
            sel_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass_cnt  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        first_q   <= first;
                        last_q    <= last;
                        dwell_q   <= dwell;
                        mode_q    <= mode_cont;
                        sel       <= first;
                        cnt       <= dwell;
                        sel_valid <= 1'b1;
                        busy      <= 1'b1;
                        pass_cnt  <= '0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    // Priority: stop, hold, dwell countdown, then address step.
                    if (stop) begin
                        sel_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (hold) begin
                        cnt <= cnt;
                    end else if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (sel != last_q) begin
                        sel <= sel + 4'd1;
                        cnt <= dwell_q;
                    end else if (mode_q) begin
                        sel      <= first_q;
                        cnt      <= dwell_q;
                        pass_cnt <= pass_cnt + 1'b1;
                    end else begin
                        sel_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        pass_cnt  <= PASS_W'(1);
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dec_scan_sequencer.sv
// Bench for dec_scan_sequencer: window/offset reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_dec_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       hold = 1'b0;
    logic       mode_cont = 1'b0;
    logic [3:0] first = '0;
    logic [3:0] last = '0;
    logic [7:0] dwell = '0;
    logic [3:0] sel;
    logic       sel_valid;
    logic       busy;
    logic       done;
    logic [7:0] pass_cnt;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    dec_scan_sequencer #(.DWELL_W(8), .PASS_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .hold(hold),
        .mode_cont(mode_cont), .first(first), .last(last), .dwell(dwell),
        .sel(sel), .sel_valid(sel_valid), .busy(busy), .done(done),
        .pass_cnt(pass_cnt)
    );

    always #5 clk = ~clk;

    // Reference: a scan is an offset into a window of len addresses; each
    // address is held for dwell+1 non-held cycles (age counts 0..dwell).
    bit         m_run = 1'b0;
    bit         m_done = 1'b0;
    bit         m_cont = 1'b0;
    logic [3:0] m_first = '0;
    logic [3:0] m_sel = '0;
    logic [7:0] m_pass = '0;
    int         m_len = 1;
    int         m_off = 0;
    int         m_age = 0;
    int         m_dwell = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_run = 1'b0; m_done = 1'b0; m_sel = '0; m_pass = '0;
        end else begin
            m_done = 1'b0;
            if (!m_run) begin
                if (start && !stop) begin
                    m_first = first;
                    m_len   = ((int'(last) - int'(first)) & 15) + 1;
                    m_dwell = int'(dwell);
                    m_cont  = mode_cont;
                    m_off   = 0;
                    m_age   = 0;
                    m_pass  = '0;
                    m_run   = 1'b1;
                end
            end else if (stop) begin
                m_run = 1'b0;
            end else if (!hold) begin
                if (m_age < m_dwell) begin
                    m_age++;
                end else if (m_off < m_len - 1) begin
                    m_off++;
                    m_age = 0;
                end else if (m_cont) begin
                    m_off = 0;
                    m_age = 0;
                    m_pass = m_pass + 8'd1;
                end else begin
                    m_run  = 1'b0;
                    m_done = 1'b1;
                    m_pass = 8'd1;
                end
            end
            if (m_run) m_sel = m_first + 4'(m_off);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [14:0] act, exp;
            act = {sel, sel_valid, busy, done, pass_cnt};
            exp = {m_sel, m_run, m_run, m_done, m_pass};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL model t=%0t act{sel,v,busy,done,pass}=%h exp=%h", $time, act, exp);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic start_scan(input int f, input int l, input int d, input bit c);
        first = 4'(f); last = 4'(l); dwell = 8'(d); mode_cont = c;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 300) begin
            tick();
            n++;
        end
        check(name, int'(busy === 1'b0), 1);
    endtask

    int exp2[8] = '{2, 2, 3, 3, 4, 4, 5, 5};
    int exp3[4] = '{14, 15, 0, 1};

    initial begin
        int cnt3, n;
        @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_sel", int'(sel), 0);
        check("rst_busy", int'({sel_valid, busy, done}), 0);
        check("rst_pass", int'(pass_cnt), 0);
        rst = 1'b0;
        tick();

        // Reset mid-run
        start_scan(2, 5, 3, 1'b0);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_sel", int'(sel), 0);
        check("midrst_flags", int'({sel_valid, busy, done}), 0);
        check("midrst_pass", int'(pass_cnt), 0);

        // Single pass
        start_scan(2, 5, 1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            check("single_sel", int'(sel), exp2[i]);
            check("single_valid", int'(sel_valid), 1);
            tick();
        end
        check("single_done", int'(done), 1);
        check("single_flags", int'({sel_valid, busy}), 0);
        check("single_pass", int'(pass_cnt), 1);
        check("single_selhold", int'(sel), 5);
        tick();
        check("single_done_clr", int'(done), 0);

        // Wrap with dwell=0, then first==last
        start_scan(14, 1, 0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("wrap_sel", int'(sel), exp3[i]);
            tick();
        end
        check("wrap_done", int'(done), 1);
        start_scan(7, 7, 4, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("one_sel", int'({sel_valid, sel}), 16 + 7);
            tick();
        end
        check("one_done", int'(done), 1);

        // Continuous, stop after 40 cycles
        start_scan(0, 15, 0, 1'b1);
        repeat (39) tick();
        check("cont_sel39", int'(sel), 7);
        check("cont_pass39", int'(pass_cnt), 2);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("cont_stop_flags", int'({sel_valid, busy, done}), 0);
        check("cont_stop_pass", int'(pass_cnt), 2);
        tick();
        check("cont_pass_hold", int'(pass_cnt), 2);

        // Hold during the second cycle of address 3
        cnt3 = 0;
        start_scan(3, 4, 2, 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (sel == 4'd3 && sel_valid) cnt3++;
            if (i == 1) hold = 1'b1;
            if (i == 6) hold = 1'b0;
            tick();
        end
        check("hold_len3", cnt3, 8);
        wait_idle("hold_idle");

        // Control collisions
        first = 4'd4; last = 4'd6;
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        check("startstop_busy", int'({sel_valid, busy}), 0);
        start_scan(1, 3, 2, 1'b0);
        tick();
        first = 4'd10; last = 4'd12; start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_ign_sel", int'(sel), 1);
        n = 0;
        while (done !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("restart_done", int'(done), 1);
        check("restart_last", int'(sel), 3);
        first = 4'd9; last = 4'd9; dwell = 8'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("done_start_sel", int'(sel), 9);
        check("done_start_busy", int'(busy), 1);
        wait_idle("done_start_idle");

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            start     = ($urandom_range(0, 7) == 0);
            stop      = ($urandom_range(0, 39) == 0);
            hold      = ($urandom_range(0, 5) == 0);
            rst       = ($urandom_range(0, 299) == 0);
            mode_cont = 1'($urandom_range(0, 1));
            first     = 4'($urandom_range(0, 15));
            last      = 4'($urandom_range(0, 15));
            dwell     = 8'($urandom_range(0, 3));
            tick();
        end
        start = 1'b0; stop = 1'b0; hold = 1'b0; rst = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
